// File: rtl/orange_frame_ctrl.sv
// orange_frame_ctrl: frame sequencer, L/C/R zone binning and decision handshake.
// Optional ORANGE_DEBOUNCE_EN debounces orange_detected over DEBOUNCE_FRAMES frames.
module orange_frame_ctrl #(
    parameter int H_ACTIVE        = 320,
    parameter int V_ACTIVE        = 240,
    parameter int LEFT_END        = 100,
    parameter int RIGHT_START     = 220,
    parameter int THRESHOLD       = 19200,
    parameter int CNT_W           = 18,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             vsync,
    input  logic             href,
    input  logic             pix_valid,
    input  logic             is_orange,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             orange_detected,
    output logic [2:0]       direction,
    output logic [CNT_W-1:0] orange_count,
    output logic             frame_error,
    output logic             overrun
);
    localparam int COL_W = $clog2(H_ACTIVE + 1);
    localparam int ROW_W = $clog2(V_ACTIVE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESHOLD);
    localparam logic [COL_W-1:0] COL_END = COL_W'(H_ACTIVE);
    localparam logic [COL_W-1:0] LEFT_C  = COL_W'(LEFT_END);
    localparam logic [COL_W-1:0] RIGHT_C = COL_W'(RIGHT_START);
    localparam logic [ROW_W-1:0] ROW_END = ROW_W'(V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        ACTIVE,
        DECIDE
    } state_t;

    state_t state, state_nxt;

    logic vsync_q, href_q, rise_q;
    logic vsync_fall, href_fall, frame_clr;
    logic [COL_W-1:0] col;
    logic col_ovf;
    logic [ROW_W-1:0] row;
    logic [CNT_W-1:0] cnt_l, cnt_c, cnt_r, total;
    logic frame_error_int;
    logic in_range, zone_l, zone_r;
    logic det, det_out;
    logic [2:0] dir_raw, dir_out;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign vsync_fall = vsync_q & ~vsync;
    assign href_fall  = href_q & ~href;
    assign frame_clr  = (state == IDLE) || ((state == SYNC) && vsync_fall);
    assign in_range   = (col < COL_END) && (row < ROW_END);
    assign zone_l     = col < LEFT_C;
    assign zone_r     = col >= RIGHT_C;

    // The rise is registered once more so DECIDE lands two edges after it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            vsync_q <= vsync;
            href_q  <= href;
            rise_q  <= vsync & ~vsync_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = SYNC;
            SYNC:    if (vsync_fall) state_nxt = ACTIVE;
            ACTIVE:  if (rise_q) state_nxt = DECIDE;
            DECIDE:  state_nxt = SYNC;
            default: state_nxt = IDLE;
        endcase
        if (!enable) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col             <= '0;
            col_ovf         <= 1'b0;
            row             <= '0;
            cnt_l           <= '0;
            cnt_c           <= '0;
            cnt_r           <= '0;
            total           <= '0;
            frame_error_int <= 1'b0;
        end else if (frame_clr) begin
            col             <= '0;
            col_ovf         <= 1'b0;
            row             <= '0;
            cnt_l           <= '0;
            cnt_c           <= '0;
            cnt_r           <= '0;
            total           <= '0;
            frame_error_int <= 1'b0;
        end else if (state == ACTIVE) begin
            if (href_fall) begin
                col     <= '0;
                col_ovf <= 1'b0;
                if (row != ROW_END) row <= row + 1'b1;
                if ((col != COL_END) || col_ovf) frame_error_int <= 1'b1;
            end else if (href && pix_valid) begin
                // col parks at H_ACTIVE; col_ovf remembers a long line.
                if (col == COL_END) col_ovf <= 1'b1;
                else                col     <= col + 1'b1;
                if (is_orange && in_range) begin
                    total <= sat_inc(total);
                    if (zone_l)      cnt_l <= sat_inc(cnt_l);
                    else if (zone_r) cnt_r <= sat_inc(cnt_r);
                    else             cnt_c <= sat_inc(cnt_c);
                end
            end
        end
    end

    always_comb begin
        det     = total > THR;
        dir_raw = 3'b000;
        if (!det)                                    dir_raw = 3'b000;
        else if ((cnt_c >= cnt_l) && (cnt_c >= cnt_r)) dir_raw = 3'b011;
        else if (cnt_l > cnt_r)                      dir_raw = 3'b001;
        else if (cnt_r > cnt_l)                      dir_raw = 3'b010;
        else                                         dir_raw = 3'b011;
    end

`ifdef ORANGE_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_FRAMES + 1);

    logic db_state, db_state_nxt;
    logic [DB_W-1:0] db_cnt, db_cnt_nxt;

    always_comb begin
        db_state_nxt = db_state;
        db_cnt_nxt   = db_cnt;
        if (det == db_state) begin
            db_cnt_nxt = '0;
        end else if ((32'(db_cnt) + 1) >= DEBOUNCE_FRAMES) begin
            db_state_nxt = det;
            db_cnt_nxt   = '0;
        end else begin
            db_cnt_nxt = db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_state <= 1'b0;
            db_cnt   <= '0;
        end else if (state == DECIDE) begin
            db_state <= db_state_nxt;
            db_cnt   <= db_cnt_nxt;
        end
    end

    assign det_out = db_state_nxt;
    assign dir_out = db_state_nxt ? dir_raw : 3'b000;
`else
    assign det_out = det;
    assign dir_out = dir_raw;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_valid    <= 1'b0;
            orange_detected <= 1'b0;
            direction       <= 3'b000;
            orange_count    <= '0;
            frame_error     <= 1'b0;
            overrun         <= 1'b0;
        end else if (state == DECIDE) begin
            result_valid    <= 1'b1;
            orange_detected <= det_out;
            direction       <= dir_out;
            orange_count    <= total;
            frame_error     <= frame_error_int;
            if (result_valid && !result_ready) overrun <= 1'b1;
        end else if (result_valid && result_ready) begin
            result_valid <= 1'b0;
        end
    end
endmodule

// File: doc/orange_frame_ctrl.md
# orange_frame_ctrl

Frame-level sequencer and decision controller for the camera orange-detection path. Tracks VSYNC/HREF framing, generates column and row positions, bins per-pixel `is_orange` hits into left, centre and right zones across a whole frame, and at each frame end produces one registered decision. The decision is a detected flag, a direction code and a total count. It is handed to the motor/command logic through a valid/ready handshake.

## Interface
Parameters:
- `H_ACTIVE`, 320: active pixels per line
- `V_ACTIVE`, 240: active lines per frame
- `LEFT_END`, 100: columns `0..LEFT_END-1` are the left zone
- `RIGHT_START`, 220: columns `RIGHT_START..H_ACTIVE-1` are the right zone; all other columns are centre
- `THRESHOLD`, 19200: detection requires a frame total strictly greater than this value (25% of 76800)
- `CNT_W`, 18: width of the zone and total counters
- `DEBOUNCE_FRAMES`, 3: consecutive-frame count, used only with `ORANGE_DEBOUNCE_EN`

Ports:
- `clk` in 1: pixel-domain clock
- `reset` in 1: asynchronous, active-high
- `enable` in 1: run control
- `vsync` in 1: camera VSYNC, high during vertical blank
- `href` in 1: line active
- `pix_valid` in 1: one-cycle strobe per completed pixel
- `is_orange` in 1: classification of the current pixel, qualified by `pix_valid`
- `result_valid` out 1: decision available
- `result_ready` in 1: consumer accepts the decision
- `orange_detected` out 1: frame or debounced detection
- `direction` out 3: `000` none, `001` left, `010` right, `011` centre
- `orange_count` out CNT_W: total orange pixels in the last frame
- `frame_error` out 1: the last frame had a malformed line
- `overrun` out 1: sticky flag, set when an unconsumed result was overwritten

## Operation
- FSM states:
  - IDLE: counters held clear. Go to SYNC when `enable`=1.
  - SYNC: wait for a vsync falling edge. On that edge, clear all counters and `frame_error_int`, then go to ACTIVE.
  - ACTIVE: count pixels. Go to DECIDE on a vsync rising edge.
  - DECIDE: one cycle. Latch the outputs, then go to SYNC.
- `enable`=0 in any state forces IDLE on the next edge. The in-progress frame is discarded and the output registers and handshake are left untouched.
- Column counter:
  - Increments on `href & pix_valid`.
  - Saturates at `H_ACTIVE`; pixels at or beyond `H_ACTIVE` are ignored.
  - Clears on the href falling edge.
- Row counter:
  - Increments on the href falling edge.
  - Lines at row ≥ `V_ACTIVE` are ignored.
- Line check: at an href falling edge in ACTIVE, if the column count ≠ `H_ACTIVE` (short or long line), set `frame_error_int`.
- Counted pixel (`href & pix_valid & is_orange`, in range):
  - Increments the zone counter L, C or R according to the current column.
  - Increments the total.
  - All counters saturate at 2^CNT_W−1.
- Raw decision, computed in DECIDE:
  - `det` = total > `THRESHOLD`.
  - Direction, evaluated in order:
    1. If not detected: `000`.
    2. Else if C ≥ L and C ≥ R: `011`.
    3. Else if L > R: `001`.
    4. Else if R > L: `010`.
    5. Else (L = R > C): `011`.
- Output handshake:
  - DECIDE loads `orange_count`, `orange_detected`, `direction` and `frame_error`, and sets `result_valid`.
  - `result_valid` stays high until the cycle in which `result_valid & result_ready` is sampled; it clears on that edge.
  - DECIDE while `result_valid`=1 and no handshake in the same cycle: the new data overwrites the old and `overrun` is set.
  - DECIDE coinciding with a handshake: the new data is loaded, `result_valid` stays 1, and `overrun` is not set.
  - `overrun` clears only on `reset`.

## Timing
- `vsync` is registered once for edge detection.
- A vsync rising edge first visible at edge k (`vsync_q`=0, `vsync`=1) puts the FSM in DECIDE after edge k+1. The outputs and `result_valid` are updated at edge k+2 (2-cycle latency).
- A vsync falling edge in SYNC puts the FSM in ACTIVE after the next edge. A pixel strobe in the same cycle as the edge is not counted.
- A vsync rise in SYNC or IDLE is ignored, so no decision is produced for partial frames.
- Reset values: FSM IDLE, all counters 0, `result_valid` 0, `orange_detected` 0, `direction` `000`, `orange_count` 0, `frame_error` 0, `overrun` 0.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous). After release, the block resynchronises on the next vsync fall.

## Configuration
- `ORANGE_DEBOUNCE_EN` defined:
  - `orange_detected` is a debounced state. It rises after `DEBOUNCE_FRAMES` consecutive frames with `det`=1 and falls after `DEBOUNCE_FRAMES` consecutive frames with `det`=0.
  - The debounce counter updates in DECIDE and resets to 0 on a decision change.
  - `direction` is `000` whenever the debounced flag is 0; otherwise it is the raw per-frame direction.
  - Frames discarded by `enable`=0 do not advance the counter.
- `ORANGE_DEBOUNCE_EN` undefined: `orange_detected` = `det` of the latest frame, and no debounce logic is built.

## Test plan
- Full 320×240 frame with orange at columns 0–99 only (24000 px), consumer ready → `result_valid` 2 cycles after the vsync rise; `orange_count`=24000, `orange_detected`=1, `direction`=`001`.
- Frame with 19200 orange pixels, then a frame with 19201 → first frame `orange_detected`=0 with `direction`=`000`; second frame `orange_detected`=1 (without the macro).
- Two frames with `result_ready` held 0 → the second result overwrites the first and `overrun`=1; a later handshake clears `result_valid` while `overrun` stays 1.
- Line of 319 pixels inside a frame → `frame_error`=1 for that frame only; the next clean frame gives `frame_error`=0.
- `reset` pulsed mid-ACTIVE, or `enable` dropped mid-frame → no result for that frame. The first result arrives after the next complete vsync fall-to-rise frame.
- With `ORANGE_DEBOUNCE_EN`, frame pattern det = 1,1,0,1,1,1 → `orange_detected` is 0 through frame 5 and rises at frame 6.
